ps2_keyboard: RTL and testbench
===============================

# ps2_keyboard

Memory-mapped PS/2 keyboard receiver for the 6502 SoC. It occupies the `ps2_cs` window decoded by `address_decoder` and sits between the external PS/2 clock/data pins and the CPU read-data multiplexer in `soc_top`, alongside `uart` and the RAM/ROM modules. Each incoming 11-bit PS/2 frame is synchronised, deglitched and validated, then the scan-code byte is buffered in a FIFO. The CPU reads it through a small register file.

## Interface
- `CLK_FREQ`, 25000000: system clock in Hz, for documentation and timeout scaling.
- `FILTER_LEN`, 8: number of consecutive identical synchronised samples required before `ps2_clk` changes filtered level.
- `FIFO_DEPTH`, 16: scan-code FIFO entries; must be a power of two, ≥2.
- `TIMEOUT_CYCLES`, 50000: mid-frame inactivity limit, 2 ms at 25 MHz; used only with `PS2_TIMEOUT_EN`.
- `clk` input 1: system clock (`clk_25mhz` at top level).
- `rst` input 1: synchronous, active-high reset.
- `cs` input 1: chip select from `ps2_cs`.
- `we` input 1: one-cycle write strobe, qualified by `cs` externally (`cs && mem_we`).
- `rd` input 1: one-cycle read strobe, asserted by the integrator in the same cycle the CPU data register captures (MC=5).
- `addr` input 8: register offset; only `addr[1:0]` is decoded.
- `data_in` input 8: write data from the CPU.
- `data_out` output 8: read data, combinational from `addr[1:0]`.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `irq` output 1: level interrupt; equals `IE && !empty`.

## Operation
- Input conditioning:
  - Both pins pass through a 2-FF synchroniser.
  - `ps2_clk` then passes through a saturating counter filter of `FILTER_LEN` samples.
  - A falling edge of the filtered clock produces a one-cycle `fall` pulse.
  - `ps2_data` is sampled from its synchroniser on `fall`.
- Receive FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), clear the shift register and bit count, then go to DATA. On `fall` with data=1, stay in IDLE.
  - DATA: on each `fall`, shift data in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the bit; parity is good when the XOR of 8 data bits and the parity bit equals 1 (odd parity). Go to STOP.
  - STOP: on `fall`:
    - If stop=1 and parity is good, push the byte.
    - If parity is bad, set `PERR` and do not push.
    - If stop=0, set `FERR` and do not push.
    - In all cases, return to IDLE.
- FIFO:
  - Read and write pointers are log2(`FIFO_DEPTH`)+1 bits wide, giving `full` and `empty` without an extra counter.
  - A push when full drops the byte and sets `OVR`; FIFO contents are unchanged.
- Registers (`addr[1:0]`):
  - 0 DATA (read): returns the FIFO head, or 0x00 if empty. `cs && rd` pops when non-empty; popping an empty FIFO has no effect.
  - 1 STATUS (read): bit0 `!empty`, bit1 `full`, bit2 `OVR`, bit3 `PERR`, bit4 `FERR`, bits 7:5 = 0.
  - 1 STATUS (write): writing 1 to bits 4:2 clears the corresponding sticky flags (W1C).
  - 2 CTRL (read/write): bit0 `IE`. Bit1 FLUSH is write-only and self-clearing: writing 1 empties the FIFO the same cycle. CTRL reads back `{7'b0, IE}`.
  - 3: reads 0x00; writes are ignored.
- Simultaneous events:
  - Push and pop in the same cycle: both occur, including when full (no overrun) and when empty (the pop is ignored, the push succeeds).
  - FLUSH in the same cycle as a push: FLUSH wins, the FIFO ends empty and the byte is lost.
  - A sticky flag set and W1C-cleared in the same cycle: set wins.
- Reset at any point:
  - FSM goes to IDLE; FIFO pointers, `OVR`, `PERR`, `FERR` and `IE` are cleared.
  - Synchroniser and filter reset to 1 (idle bus level).
  - Any partial frame is discarded.

## Timing
- Reset values: `data_out` = 0x00 (FIFO empty for any `addr`), `irq` = 0.
- Pin-to-`fall` latency: 2 synchroniser cycles + `FILTER_LEN` cycles after the raw clock falls.
- Push occurs on the clock edge at which the STOP-state `fall` is processed.
- STATUS bit0, `irq` and DATA reflect the new byte on the following cycle.
- Pop takes effect at the clock edge ending the `rd` cycle. `data_out` shows the next entry from the next cycle onward.
- `data_out` is combinational: it must be stable within the cycle that `rd` is asserted so the SoC capture register latches the pre-pop value.
- Maximum PS/2 clock rate supported: 16.7 kHz with ≥ 30 µs half-periods, far above `FILTER_LEN` at 25 MHz.

## Configuration
- `PS2_TIMEOUT_EN` defined:
  - A counter of `clog2(TIMEOUT_CYCLES)` bits increments every cycle while the FSM is not IDLE and resets on every `fall`.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, `FERR` is set and the partial byte is discarded.
- `PS2_TIMEOUT_EN` undefined:
  - No counter is built.
  - A stalled frame stays in its state until further `fall` pulses or reset.

## Test plan
- Valid frame: send 0x1C (start 0, data LSB-first, parity 0, stop 1) → STATUS=0x01, `irq`=1 with `IE`=1, DATA=0x1C; after a read pop, STATUS=0x00 and `irq`=0.
- Parity error: send 0x1C with parity 1 → STATUS=0x08 and FIFO empty; W1C write 0x08 to STATUS → STATUS=0x00.
- Overflow: send 17 frames 0x01..0x11 → STATUS=0x07; reads return 0x01..0x10 in order, then STATUS=0x04.
- Glitch rejection: a 3-cycle low pulse on `ps2_clk` while IDLE with `ps2_data`=0 → FSM stays IDLE; a following valid 0xF0 frame is received intact.
- Timeout (`PS2_TIMEOUT_EN`): start bit plus 3 data bits, then idle for `TIMEOUT_CYCLES`+10 cycles → STATUS=0x10; a following frame 0x5A reads back 0x5A.
- Simultaneous events:
  - Push and pop in the same cycle with the FIFO full → no `OVR`, still full, head advances.
  - FLUSH while a push is pending → STATUS bit0=0.
  - `rst` mid-frame → all outputs at reset values.

Source files
------------

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: memory-mapped PS/2 keyboard receiver for the 6502 SoC.
// Pins are synchronised, the PS/2 clock is deglitched by a saturating
// counter, 11-bit frames are validated (odd parity, stop bit) and good
// scan codes are queued in a FIFO read through four byte registers.
// Optional build macro: PS2_TIMEOUT_EN adds a mid-frame inactivity timeout.
//
// Register handshake: a register access is a single-cycle strobe. A write
// takes effect at the clock edge ending the cycle in which we is high; a
// read returns data_out combinationally during the rd cycle and any pop
// takes effect at the edge ending that cycle. There is no ready/stall.
`timescale 1ns/1ps

module ps2_keyboard #(
    parameter int CLK_FREQ       = 25000000,
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic       rd,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);

    // Reject parameter sets the pointer and counter arithmetic cannot handle.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        FILTER_LEN < 1 || CLK_FREQ <= 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_keyboard: unsupported parameter values");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            clk_filt;
    logic [FW-1:0]   filt_cnt;
    logic            fall;

    logic [7:0]      shift_reg;
    logic [2:0]      bit_cnt;
    logic            par_bit;
    logic            parity_ok;
    logic            push, set_perr, set_ferr, timeout_hit;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            empty, full, pop, push_ok, overrun, flush;
    logic [7:0]      head;

    logic            wr_en;
    logic [1:0]      sel;
    logic [2:0]      flag_clr;
    logic            ovr, perr, ferr, ie;
    logic            unused_bits;

    assign sel         = addr[1:0];
    assign wr_en       = cs && we;
    assign unused_bits = ^{addr[7:2], data_in[7:5]};

    // Two-flop synchronisers on both pins; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples;
    // a 1->0 flip emits a one-cycle fall pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt;

    // Inactivity counter: runs mid-frame, restarts on every fall.
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE || fall) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Receive FSM next-state logic; a timeout abandons any frame in progress.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (fall && !dat_s2) state_next = ST_DATA;
            ST_DATA:   if (fall && bit_cnt == 3'd7) state_next = ST_PARITY;
            ST_PARITY: if (fall) state_next = ST_STOP;
            ST_STOP:   if (fall) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_next = ST_IDLE;
        end
    end

    // Frame datapath: LSB-first shift register, bit counter and parity bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end
                ST_DATA: begin
                    shift_reg <= {dat_s2, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                ST_PARITY: par_bit <= dat_s2;
                default: ;
            endcase
        end
    end

    assign parity_ok = ^{shift_reg, par_bit};
    assign push      = fall && (state == ST_STOP) && dat_s2 && parity_ok;
    assign set_perr  = fall && (state == ST_STOP) && !parity_ok;
    assign set_ferr  = (fall && (state == ST_STOP) && !dat_s2) || timeout_hit;

    // FIFO bookkeeping: the extra pointer MSB separates full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = cs && rd && (sel == 2'd0) && !empty;
    assign flush   = wr_en && (sel == 2'd2) && data_in[1];
    assign push_ok = push && (!full || pop) && !flush;
    assign overrun = push && full && !pop && !flush;
    assign head    = mem[rd_ptr[AW-1:0]];

    // FIFO pointers; flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= shift_reg;
        end
    end

    assign flag_clr = (wr_en && sel == 2'd1) ? data_in[4:2] : 3'b000;

    // Sticky error flags (set wins over W1C) and interrupt enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr  <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
            ie   <= 1'b0;
        end else begin
            ovr  <= (ovr  && !flag_clr[0]) || overrun;
            perr <= (perr && !flag_clr[1]) || set_perr;
            ferr <= (ferr && !flag_clr[2]) || set_ferr;
            if (wr_en && sel == 2'd2) begin
                ie <= data_in[0];
            end
        end
    end

    // Combinational register read mux.
    always_comb begin
        data_out = 8'h00;
        case (sel)
            2'd0:    data_out = empty ? 8'h00 : head;
            2'd1:    data_out = {3'b000, ferr, perr, ovr, full, !empty};
            2'd2:    data_out = {7'b0000000, ie};
            default: data_out = 8'h00;
        endcase
    end

    assign irq = ie && !empty;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed and randomized frames against a queue-based
// model of the receiver's externally visible behaviour.
`timescale 1ns/1ps

module tb_ps2_keyboard;

    localparam int DEPTH   = 16;
    localparam int HALF    = 20;
    localparam int TIMEOUT = 50000;

    logic       clk = 1'b0;
    logic       rst, cs, we, rd;
    logic [7:0] addr, data_in;
    logic [7:0] data_out;
    logic       ps2_clk, ps2_data;
    logic       irq;

    logic [7:0] exp_q[$];
    bit         m_ovr, m_perr, m_ferr, m_ie;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] act_data;
    logic [7:0] rdat;
    logic [7:0] exp_head;

    // 25 MHz system clock.
    always #20 clk = ~clk;

    ps2_keyboard dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .we       (we),
        .rd       (rd),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .irq      (irq)
    );

    // Absolute time limit so the run always terminates.
    initial begin
        #(40 * 200000);
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {3'b000, m_ferr, m_perr, m_ovr, exp_q.size() == DEPTH, exp_q.size() != 0};
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ~(^b) ^ bad_par;
        f[10]  = ~bad_stop;
        return f;
    endfunction

    // Model: what a complete frame does to the visible state.
    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_par)  m_perr = 1'b1;
        if (bad_stop) m_ferr = 1'b1;
        if (!bad_par && !bad_stop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else                      m_ovr = 1'b1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = {6'b0, a}; data_in = d; cs = 1'b1; we = 1'b1;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = {6'b0, a}; cs = 1'b1; rd = 1'b1;
        #1 d = data_out;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [7:0] d;
        bus_read(2'd1, d);
        check(tag, d, exp_status());
        check({tag, "_irq"}, {7'b0, irq}, {7'b0, (m_ie && exp_q.size() != 0)});
    endtask

    task automatic check_pop(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        e = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        bus_read(2'd0, d);
        check(tag, d, e);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    // Drive frame bits first..last. action 1 pops DATA, action 2 writes
    // FLUSH|IE, in the cycle the stop-bit fall is processed
    // (2 sync + FILTER_LEN cycles after the pin falls, acted on at the next edge).
    task automatic send_bits(input logic [10:0] f, input int first, input int last, input int action);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && action != 0) begin
                repeat (10) @(negedge clk);
                addr    = (action == 1) ? 8'h00 : 8'h02;
                data_in = 8'h03;
                cs      = 1'b1;
                rd      = (action == 1);
                we      = (action == 2);
                #1 act_data = data_out;
                @(negedge clk);
                cs = 1'b0; rd = 1'b0; we = 1'b0;
                repeat (HALF - 11) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits(make_frame(b, bad_par, bad_stop), 0, 10, 0);
        model_frame(b, bad_par, bad_stop);
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 4; a++) begin
            addr = a[7:0];
            #1 check(tag, data_out, 8'h00);
        end
        check({tag, "_irq"}, {7'b0, irq}, 8'h00);
    endtask

    initial begin
        logic [7:0] b;
        int         k;

        // Clock/reset
        rst = 1'b1; cs = 1'b0; we = 1'b0; rd = 1'b0;
        addr = 8'h00; data_in = 8'h00; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Interrupt enable
        bus_write(2'd2, 8'h01); m_ie = 1'b1;
        bus_read(2'd2, rdat);
        check("ctrl_rb", rdat, 8'h01);

        // Valid frame 0x1C
        send_frame(8'h1C, 1'b0, 1'b0);
        check_status("valid_status");
        check_pop("valid_data");
        check_status("valid_after_pop");
        check_pop("empty_read");

        // Parity error, then W1C
        send_frame(8'h1C, 1'b1, 1'b0);
        check_status("perr_status");
        bus_write(2'd1, 8'h08); m_perr = 1'b0;
        check_status("perr_cleared");

        // Framing error, then W1C
        send_frame(8'h42, 1'b0, 1'b1);
        check_status("ferr_status");
        bus_write(2'd1, 8'h10); m_ferr = 1'b0;
        check_status("ferr_cleared");

        // Glitch on ps2_clk while idle with data low
        @(negedge clk);
        ps2_data = 1'b0; ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (30) @(negedge clk);
        check_status("glitch_status");
        send_frame(8'hF0, 1'b0, 1'b0);
        check_pop("glitch_f0");

        // Overflow: 17 frames into a 16-entry FIFO
        for (int i = 1; i <= 17; i++) send_frame(i[7:0], 1'b0, 1'b0);
        check_status("ovr_status");
        for (int i = 1; i <= 16; i++) check_pop("ovr_data");
        check_status("ovr_after_drain");
        bus_write(2'd1, 8'h04); m_ovr = 1'b0;
        check_status("ovr_cleared");

        // Push and pop in the same cycle while full
        for (int i = 0; i < 16; i++) send_frame(8'h20 + i[7:0], 1'b0, 1'b0);
        check_status("pp_full");
        exp_head = exp_q[0];
        send_bits(make_frame(8'h99, 1'b0, 1'b0), 0, 10, 1);
        void'(exp_q.pop_front());
        model_frame(8'h99, 1'b0, 1'b0);
        check("pp_head", act_data, exp_head);
        check_status("pp_status");
        for (int i = 0; i < 16; i++) check_pop("pp_drain");

        // FLUSH in the same cycle as a push
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_bits(make_frame(8'h33, 1'b0, 1'b0), 0, 10, 2);
        exp_q.delete();
        check_status("flush_status");
        check_pop("flush_data");

`ifdef PS2_TIMEOUT_EN
        // Stalled frame is abandoned after the timeout
        send_bits(make_frame(8'h5A, 1'b0, 1'b0), 0, 3, 0);
        repeat (TIMEOUT + 10) @(negedge clk);
        m_ferr = 1'b1;
        check_status("timeout_status");
        bus_write(2'd1, 8'h10); m_ferr = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0);
        check_pop("timeout_next");
`else
        // Stalled frame waits for the rest of its bits
        send_bits(make_frame(8'h5A, 1'b0, 1'b0), 0, 3, 0);
        repeat (500) @(negedge clk);
        check_status("stall_status");
        send_bits(make_frame(8'h5A, 1'b0, 1'b0), 4, 10, 0);
        model_frame(8'h5A, 1'b0, 1'b0);
        check_pop("stall_resume");
`endif

        // Randomized frames, errors and reads against the model
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom_range(0, 255));
            k = $urandom_range(0, 9);
            send_frame(b, k == 0, k == 1);
            if ($urandom_range(0, 2) == 0) begin
                check_status("rnd_status");
                bus_write(2'd1, 8'h1C);
                m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) check_pop("rnd_data");
        end
        check_status("rnd_final_status");
        while (exp_q.size() != 0) check_pop("rnd_drain");
        check_status("rnd_drained");

        // Reset in the middle of a frame
        send_frame(8'h77, 1'b0, 1'b0);
        send_bits(make_frame(8'hC3, 1'b0, 1'b0), 0, 4, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ie = 1'b0;
        check_all_zero("midrst");
        send_frame(8'h3C, 1'b0, 1'b0);
        check_status("midrst_next_status");
        check_pop("midrst_next_data");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
